// File: rtl/plab5_mcore_mem_sec_req_arb_if.sv
// rtl/plab5_mcore_mem_sec_req_arb_if.sv - cache/memory request-response port bundle
//
// One bundle carries a full memory port: request channel (control, data,
// security level, val/rdy) and response channel (control, data, insecure
// flag, val/rdy).
//   master : the side that issues requests and consumes responses
//   slave  : the side that accepts requests and returns responses
interface plab5_mcore_mem_sec_req_arb_if #(
  parameter int p_req_cnbits  = 45,
  parameter int p_resp_cnbits = 15,
  parameter int p_data_nbits  = 32
);
  logic [p_req_cnbits-1:0]  req_control;
  logic [p_data_nbits-1:0]  req_data;
  logic                     req_sec_level;
  logic                     req_val;
  logic                     req_rdy;
  logic [p_resp_cnbits-1:0] resp_control;
  logic [p_data_nbits-1:0]  resp_data;
  logic                     resp_insecure;
  logic                     resp_val;
  logic                     resp_rdy;

  modport master (
    output req_control, req_data, req_sec_level, req_val,
    input  req_rdy,
    input  resp_control, resp_data, resp_insecure, resp_val,
    output resp_rdy
  );

  modport slave (
    input  req_control, req_data, req_sec_level, req_val,
    output req_rdy,
    output resp_control, resp_data, resp_insecure, resp_val,
    input  resp_rdy
  );
endinterface

// File: rtl/plab5_mcore_mem_sec_req_arb.sv
// rtl/plab5_mcore_mem_sec_req_arb.sv - two-port round-robin arbiter in front of the secure memory controller
//
// Grants one cache request at a time, forwards it (with its security level)
// to the memory controller, and passes the single outstanding response back
// to its owner combinationally. Counts insecure responses per port.
//   clk_i, reset_i    : clock, synchronous active-high reset
//   req0_if, req1_if  : cache ports (slave side)
//   mem_if            : controller port (master side); resp_insecure is the
//                       controller's insecure flag
//   resp_sec_level_o  : security level of the in-flight transaction owner
//   insec_cnt0_o/1_o  : saturating insecure-response counters
module plab5_mcore_mem_sec_req_arb #(
  parameter int p_opaque_nbits = 8,
  parameter int p_addr_nbits   = 32,
  parameter int p_data_nbits   = 32,
  parameter int p_cnt_nbits    = 8
) (
  input  logic                               clk_i,
  input  logic                               reset_i,
  plab5_mcore_mem_sec_req_arb_if.slave       req0_if,
  plab5_mcore_mem_sec_req_arb_if.slave       req1_if,
  plab5_mcore_mem_sec_req_arb_if.master      mem_if,
  output logic                               resp_sec_level_o,
  output logic [p_cnt_nbits-1:0]             insec_cnt0_o,
  output logic [p_cnt_nbits-1:0]             insec_cnt1_o
);

  // Message control fields exclude data: req = type+opaque+addr+len,
  // resp = type+opaque+test+len.
  localparam int c_len_nbits = $clog2(p_data_nbits/8);
  localparam int req_cnbits  = 3 + p_opaque_nbits + p_addr_nbits + c_len_nbits;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t                  state_q;
  logic                    rr_q;
  logic                    owner_q;
  logic                    lvl_q;
  logic [req_cnbits-1:0]   ctrl_q;
  logic [p_data_nbits-1:0] data_q;
  logic [p_cnt_nbits-1:0]  cnt0_q;
  logic [p_cnt_nbits-1:0]  cnt1_q;

  logic any_val;
  logic grant;
  logic owner_rdy;
  logic resp_hs;
  logic in_idle;
  logic in_send;
  logic in_wait;

  assign any_val   = req0_if.req_val || req1_if.req_val;
  // Lone requester wins; a tie goes to the round-robin pointer.
  assign grant     = (req0_if.req_val && req1_if.req_val) ? rr_q : req1_if.req_val;
  assign owner_rdy = owner_q ? req1_if.resp_rdy : req0_if.resp_rdy;
  assign resp_hs   = mem_if.resp_val && owner_rdy;

  // Reset forces every handshake output low regardless of the held state.
  assign in_idle = !reset_i && (state_q == IDLE);
  assign in_send = !reset_i && (state_q == SEND);
  assign in_wait = !reset_i && (state_q == WAIT);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      owner_q <= 1'b0;
      lvl_q   <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_val) begin
            owner_q <= grant;
            lvl_q   <= grant ? req1_if.req_sec_level : req0_if.req_sec_level;
            ctrl_q  <= grant ? req1_if.req_control   : req0_if.req_control;
            data_q  <= grant ? req1_if.req_data      : req0_if.req_data;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (mem_if.req_rdy) state_q <= WAIT;
        end
        WAIT: begin
          if (resp_hs) begin
            state_q <= IDLE;
            rr_q    <= ~owner_q;
            if (mem_if.resp_insecure) begin
              if (owner_q) begin
                if (cnt1_q != '1) cnt1_q <= cnt1_q + p_cnt_nbits'(1);
              end else begin
                if (cnt0_q != '1) cnt0_q <= cnt0_q + p_cnt_nbits'(1);
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_if.req_rdy = in_idle && any_val && !grant;
  assign req1_if.req_rdy = in_idle && any_val &&  grant;

  assign mem_if.req_val       = in_send;
  assign mem_if.req_control   = ctrl_q;
  assign mem_if.req_data      = data_q;
  assign mem_if.req_sec_level = (in_send || in_wait) && lvl_q;
  assign resp_sec_level_o     = (in_send || in_wait) && lvl_q;

  // Response path is a pure pass-through; only val is steered to the owner.
  assign req0_if.resp_val      = in_wait && !owner_q && mem_if.resp_val;
  assign req1_if.resp_val      = in_wait &&  owner_q && mem_if.resp_val;
  assign req0_if.resp_control  = mem_if.resp_control;
  assign req1_if.resp_control  = mem_if.resp_control;
  assign req0_if.resp_data     = mem_if.resp_data;
  assign req1_if.resp_data     = mem_if.resp_data;
  assign req0_if.resp_insecure = mem_if.resp_insecure;
  assign req1_if.resp_insecure = mem_if.resp_insecure;
  assign mem_if.resp_rdy       = in_wait && owner_rdy;

  assign insec_cnt0_o = cnt0_q;
  assign insec_cnt1_o = cnt1_q;

endmodule

// File: tb/tb_plab5_mcore_mem_sec_req_arb.sv
// tb/tb_plab5_mcore_mem_sec_req_arb.sv - self-checking bench for the secure request arbiter
module tb_plab5_mcore_mem_sec_req_arb;
  localparam int OPQ     = 8;
  localparam int ADR     = 32;
  localparam int DAT     = 32;
  localparam int CNT     = 8;
  localparam int REQ_CN  = 3 + OPQ + ADR + 2;
  localparam int RESP_CN = 3 + OPQ + 2 + 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  plab5_mcore_mem_sec_req_arb_if #(.p_req_cnbits(REQ_CN), .p_resp_cnbits(RESP_CN), .p_data_nbits(DAT)) p0 ();
  plab5_mcore_mem_sec_req_arb_if #(.p_req_cnbits(REQ_CN), .p_resp_cnbits(RESP_CN), .p_data_nbits(DAT)) p1 ();
  plab5_mcore_mem_sec_req_arb_if #(.p_req_cnbits(REQ_CN), .p_resp_cnbits(RESP_CN), .p_data_nbits(DAT)) mem ();

  logic           resp_sec_level;
  logic [CNT-1:0] cnt0;
  logic [CNT-1:0] cnt1;

  plab5_mcore_mem_sec_req_arb #(
    .p_opaque_nbits(OPQ), .p_addr_nbits(ADR), .p_data_nbits(DAT), .p_cnt_nbits(CNT)
  ) dut (
    .clk_i(clk), .reset_i(reset),
    .req0_if(p0), .req1_if(p1), .mem_if(mem),
    .resp_sec_level_o(resp_sec_level),
    .insec_cnt0_o(cnt0), .insec_cnt1_o(cnt1)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Transaction-level model: at most one pending transaction, which is
  // either not yet sent downstream or awaiting its response.
  bit                m_pend;
  bit                m_sent;
  bit                m_owner;
  bit                m_lvl;
  bit                m_rr;
  logic [REQ_CN-1:0] m_ctrl;
  logic [DAT-1:0]    m_data;
  int                m_cnt[2];
  int                grants[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit pick();
    if (p0.req_val && p1.req_val) return m_rr;
    return p1.req_val;
  endfunction

  task automatic compare();
    bit rs, anyv, g, wt, xv0, xv1;
    rs   = reset;
    anyv = p0.req_val || p1.req_val;
    g    = pick();
    wt   = !rs && m_pend && m_sent;
    xv0  = wt && !m_owner && mem.resp_val;
    xv1  = wt &&  m_owner && mem.resp_val;
    if (p0.req_rdy === 1'b1) grants.push_back(0);
    if (p1.req_rdy === 1'b1) grants.push_back(1);
    chk("req0_rdy", p0.req_rdy, !rs && !m_pend && anyv && !g);
    chk("req1_rdy", p1.req_rdy, !rs && !m_pend && anyv && g);
    chk("mem_req_val", mem.req_val, !rs && m_pend && !m_sent);
    chk("req_sec_level", mem.req_sec_level, !rs && m_pend && m_lvl);
    chk("resp_sec_level", resp_sec_level, !rs && m_pend && m_lvl);
    chk("resp0_val", p0.resp_val, xv0);
    chk("resp1_val", p1.resp_val, xv1);
    chk("mem_resp_rdy", mem.resp_rdy, wt && (m_owner ? p1.resp_rdy : p0.resp_rdy));
    chk("insec_cnt0", cnt0, m_cnt[0]);
    chk("insec_cnt1", cnt1, m_cnt[1]);
    if (!rs && m_pend && !m_sent) begin
      chk("mem_req_control", mem.req_control, m_ctrl);
      chk("mem_req_data", mem.req_data, m_data);
    end
    if (xv0) begin
      chk("resp0_control", p0.resp_control, mem.resp_control);
      chk("resp0_data", p0.resp_data, mem.resp_data);
      chk("resp0_insecure", p0.resp_insecure, mem.resp_insecure);
    end
    if (xv1) begin
      chk("resp1_control", p1.resp_control, mem.resp_control);
      chk("resp1_data", p1.resp_data, mem.resp_data);
      chk("resp1_insecure", p1.resp_insecure, mem.resp_insecure);
    end
  endtask

  task automatic model_update();
    bit g;
    if (reset) begin
      m_pend = 0; m_sent = 0; m_rr = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (!m_pend) begin
      if (p0.req_val || p1.req_val) begin
        g       = pick();
        m_pend  = 1;
        m_sent  = 0;
        m_owner = g;
        m_lvl   = g ? p1.req_sec_level : p0.req_sec_level;
        m_ctrl  = g ? p1.req_control   : p0.req_control;
        m_data  = g ? p1.req_data      : p0.req_data;
      end
    end else if (!m_sent) begin
      if (mem.req_rdy) m_sent = 1;
    end else if (mem.resp_val && (m_owner ? p1.resp_rdy : p0.resp_rdy)) begin
      m_pend = 0;
      m_rr   = !m_owner;
      if (mem.resp_insecure && m_cnt[m_owner] < (1 << CNT) - 1) m_cnt[m_owner]++;
    end
  endtask

  // Inputs are set at the falling edge; outputs are checked just after.
  task automatic step();
    #1;
    compare();
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p0.req_val = 0; p0.req_control = '0; p0.req_data = '0; p0.req_sec_level = 0; p0.resp_rdy = 0;
    p1.req_val = 0; p1.req_control = '0; p1.req_data = '0; p1.req_sec_level = 0; p1.resp_rdy = 0;
    mem.req_rdy = 0; mem.resp_val = 0; mem.resp_control = '0; mem.resp_data = '0; mem.resp_insecure = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  logic [REQ_CN-1:0] c1;
  logic [REQ_CN-1:0] c3;

  initial begin
    idle_inputs();
    reset = 1;
    @(negedge clk);
    step();
    step();
    reset = 0;
    #1;
    chk("reset_cnt0", cnt0, 0);
    chk("reset_cnt1", cnt1, 0);
    chk("reset_mem_val", mem.req_val, 0);

    // Single port-0 read of 0x0100, data DEADBEEF returned in the same cycle.
    c1 = {3'd0, 8'h00, 32'h0000_0100, 2'd0};
    p0.req_val = 1; p0.req_control = c1; mem.req_rdy = 1;
    #1 chk("t1_req0_rdy", p0.req_rdy, 1);
    step();
    p0.req_val = 0;
    #1;
    chk("t1_mem_val", mem.req_val, 1);
    chk("t1_mem_ctrl", mem.req_control, {3'd0, 8'h00, 32'h0000_0100, 2'd0});
    chk("t1_req_sec", mem.req_sec_level, 0);
    step();
    mem.resp_val = 1; mem.resp_data = 32'hDEADBEEF; p0.resp_rdy = 1;
    #1;
    chk("t1_resp0_val", p0.resp_val, 1);
    chk("t1_resp0_data", p0.resp_data, 32'hDEADBEEF);
    chk("t1_resp0_insec", p0.resp_insecure, 0);
    chk("t1_resp1_val", p1.resp_val, 0);
    step();

    // Both ports valid from reset: grants 0, 1, 0.
    do_reset();
    grants.delete();
    p0.req_val = 1; p1.req_val = 1; p0.req_control = REQ_CN'(5); p1.req_control = REQ_CN'(9);
    mem.req_rdy = 1; mem.resp_val = 1; p0.resp_rdy = 1; p1.resp_rdy = 1;
    repeat (9) step();
    chk("t2_ngrants", grants.size() >= 3, 1);
    if (grants.size() >= 3) begin
      chk("t2_grant0", grants[0], 0);
      chk("t2_grant1", grants[1], 1);
      chk("t2_grant2", grants[2], 0);
    end

    // Back-pressure for 5 cycles on the downstream request.
    idle_inputs();
    c3 = {3'd1, 8'h3C, 32'h1234_5678, 2'd2};
    p1.req_val = 1; p1.req_control = c3; p1.req_data = 32'hA5A5_0F0F; p1.req_sec_level = 1;
    step();
    p0.req_val = 1;
    for (int i = 0; i < 6; i++) begin
      if (i == 5) mem.req_rdy = 1;
      #1;
      chk("t3_mem_val", mem.req_val, 1);
      chk("t3_mem_ctrl", mem.req_control, {3'd1, 8'h3C, 32'h1234_5678, 2'd2});
      chk("t3_mem_data", mem.req_data, 32'hA5A5_0F0F);
      chk("t3_req_sec", mem.req_sec_level, 1);
      chk("t3_rdy0", p0.req_rdy, 0);
      chk("t3_rdy1", p1.req_rdy, 0);
      step();
    end
    p0.req_val = 0; p1.req_val = 0; mem.resp_val = 1; p1.resp_rdy = 1;
    step();

    // Insecure responses on port 1, then saturation.
    do_reset();
    p1.req_val = 1; mem.req_rdy = 1; mem.resp_val = 1; mem.resp_insecure = 1; p1.resp_rdy = 1;
    step();
    step();
    #1 chk("t4_resp1_insec", p1.resp_insecure, 1);
    step();
    #1 chk("t4_cnt1_one", cnt1, 1);
    repeat (256 * 3) step();
    #1;
    chk("t4_cnt1_sat", cnt1, 8'hFF);
    chk("t4_cnt0_zero", cnt0, 0);

    // Response back-pressure on port 0 while port 1 waits.
    idle_inputs();
    p0.req_val = 1; mem.req_rdy = 1;
    step();
    step();
    p0.req_val = 0; p1.req_val = 1; mem.resp_val = 1; p0.resp_rdy = 0;
    repeat (3) begin
      #1;
      chk("t5_mem_resp_rdy", mem.resp_rdy, 0);
      chk("t5_rdy1", p1.req_rdy, 0);
      step();
    end
    p0.resp_rdy = 1;
    #1 chk("t5_mem_resp_rdy_hs", mem.resp_rdy, 1);
    step();
    #1 chk("t5_grant_after", p1.req_rdy, 1);
    step();

    // Reset while waiting for a response.
    mem.resp_val = 0; p1.req_val = 0;
    step();
    reset = 1;
    step();
    reset = 0;
    idle_inputs();
    #1;
    chk("t6_cnt1", cnt1, 0);
    chk("t6_mem_val", mem.req_val, 0);
    chk("t6_resp1_val", p1.resp_val, 0);
    p0.req_val = 1; p1.req_val = 1;
    #1 chk("t6_rr_zero", p0.req_rdy, 1);
    step();
    p0.req_val = 0; p1.req_val = 0; mem.req_rdy = 1; mem.resp_val = 1; p0.resp_rdy = 1;
    step();
    step();
    p1.req_val = 1;
    #1 chk("t6_port1_grant", p1.req_rdy, 1);
    step();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      reset             = ($urandom_range(0, 99) == 0);
      p0.req_val        = $urandom_range(0, 1);
      p1.req_val        = $urandom_range(0, 1);
      p0.req_control    = REQ_CN'({$urandom(), $urandom()});
      p1.req_control    = REQ_CN'({$urandom(), $urandom()});
      p0.req_data       = $urandom();
      p1.req_data       = $urandom();
      p0.req_sec_level  = $urandom_range(0, 1);
      p1.req_sec_level  = $urandom_range(0, 1);
      p0.resp_rdy       = ($urandom_range(0, 3) != 0);
      p1.resp_rdy       = ($urandom_range(0, 3) != 0);
      mem.req_rdy       = ($urandom_range(0, 3) != 0);
      mem.resp_val      = $urandom_range(0, 1);
      mem.resp_control  = RESP_CN'($urandom());
      mem.resp_data     = $urandom();
      mem.resp_insecure = $urandom_range(0, 1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/plab5_mcore_mem_sec_req_arb.md
Name: plab5_mcore_mem_sec_req_arb

Overview:
- Two-requester arbiter sitting directly upstream of the memory access controller (memory address space controller).
- Selects one cache request at a time from port 0 or port 1. Drives the controller's cache2mem request interface and req_sec_level, then routes the single outstanding response back to its owner together with the controller's insecure flag.
- Keeps a saturating per-port count of insecure (faked) responses for debug and monitoring.

Parameters:
- p_opaque_nbits, 8, mem message opaque field width
- p_addr_nbits, 32, mem message address width
- p_data_nbits, 32, mem message data width
- req_cnbits, VC_MEM_REQ_MSG_NBITS(o,a,d) - p_data_nbits, request control field width (derived)
- resp_cnbits, VC_MEM_RESP_MSG_NBITS(o,d) - p_data_nbits, response control field width (derived)
- p_cnt_nbits, 8, width of each insecure-event counter

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- reqN_control  in  req_cnbits  port N request control, N=0,1
- reqN_data  in  p_data_nbits  port N request data
- reqN_sec_level  in  1  port N security level (0 = normal, 1 = secure)
- reqN_val / reqN_rdy  in / out  1  port N request handshake
- respN_control  out  resp_cnbits  port N response control
- respN_data  out  p_data_nbits  port N response data
- respN_insecure  out  1  response was faked (access denied)
- respN_val / respN_rdy  out / in  1  port N response handshake
- cache2mem_req_control  out  req_cnbits  request control to controller
- cache2mem_req_data  out  p_data_nbits  request data to controller
- cache2mem_req_val / cache2mem_req_rdy  out / in  1  request handshake to controller
- req_sec_level  out  1  security level of the in-flight request
- mem2cache_resp_control  in  resp_cnbits  response control from controller
- mem2cache_resp_data  in  p_data_nbits  response data from controller
- mem2cache_resp_val / mem2cache_resp_rdy  in / out  1  response handshake from controller
- insecure  in  1  controller's insecure flag, sampled with the response
- resp_sec_level  out  1  security level of the response owner (equals latched level)
- insec_cnt0, insec_cnt1  out  p_cnt_nbits  insecure-response counters per port

Behaviour:
- State register: 2 bits. States are IDLE=0, SEND=1, WAIT=2.
- Latched registers: owner (1b), lvl (1b), ctrl, data, rr_ptr (1b).
- Reset (synchronous, can occur in any state):
  - state=IDLE, rr_ptr=0, owner=0, lvl=0, both counters=0.
  - Any in-flight transaction is dropped and no response is forwarded.
  - Outputs while reset is asserted: all val/rdy=0, req_sec_level=0, resp_sec_level=0.
- IDLE:
  - Grant rule: if only one reqN_val is high, grant N. If both are high, grant rr_ptr.
  - reqN_rdy=1 only for the granted port, and only in IDLE while not in reset. The other rdy=0.
  - On grant, latch control, data, sec_level and owner; next state = SEND.
  - If no valid request, stay in IDLE with all rdy=0.
  - cache2mem_req_val=0 and mem2cache_resp_rdy=0.
- SEND:
  - cache2mem_req_val=1; cache2mem_req_control/data come from the latched registers; req_sec_level=lvl.
  - The outputs stay stable until cache2mem_req_rdy=1. On that handshake, next state = WAIT.
  - A request is accepted at cycle t and appears downstream at t+1, so minimum latency is 1 cycle.
- WAIT:
  - Response path is combinational pass-through to port owner:
    - resp[owner]_val = mem2cache_resp_val.
    - resp[owner]_control/data = mem2cache_resp_control/data.
    - resp[owner]_insecure = insecure.
    - mem2cache_resp_rdy = resp[owner]_rdy.
  - The non-owner port has resp_val=0.
  - On the handshake (mem2cache_resp_val && resp[owner]_rdy):
    - next state = IDLE.
    - rr_ptr = ~owner.
    - if insecure=1, insec_cnt[owner] += 1, saturating at all-ones.
- req_sec_level and resp_sec_level equal lvl in SEND and WAIT, and are 0 in IDLE.
- At most one transaction is outstanding. A new grant cannot occur in the same cycle as a response handshake; the next grant is earliest in the following IDLE cycle.
- Response data and control are not registered, so there is zero added response latency.
- A reqN_val held high with no grant is legal and waits indefinitely. Starvation is bounded to one transaction by the round-robin rule.

Test Plan:
- Single port 0 read, sec_level=0, address 0x0100: req0_rdy pulses at t, cache2mem_req_val=1 at t+1 with identical control and req_sec_level=0. Controller response data 0xDEADBEEF is returned on resp0 in the same cycle, with resp0_insecure=0 and resp1_val=0.
- Both ports valid from reset: port 0 is granted first (rr_ptr=0), port 1 is granted next, then port 0 again. The observed grant sequence is 0, 1, 0.
- Back-pressure: cache2mem_req_rdy held at 0 for 5 cycles, then 1. cache2mem_req_val and all payload bits stay stable for all 6 cycles, and both reqN_rdy=0 throughout.
- Insecure response on port 1 (insecure=1 at the handshake): resp1_insecure=1 and insec_cnt1 goes 0→1. After 256 insecure responses with p_cnt_nbits=8, insec_cnt1 saturates at 0xFF.
- resp0_rdy held at 0 for 3 cycles while mem2cache_resp_val=1: mem2cache_resp_rdy=0 for those cycles and the arbiter stays in WAIT. No new grant occurs until the cycle after the handshake.
- Reset asserted during WAIT: next cycle state=IDLE, all val=0, counters=0, rr_ptr=0. A later port 1 request is granted normally.
